// File: rtl/ram_access_ctrl_pkg.sv
// rtl/ram_access_ctrl_pkg.sv - shared state encoding and strobe helpers for ram_access_ctrl
//
// Purpose: state encoding constants for the controller FSM and the
// byte-enable to bit-mask expansion used by the partial-store merge.
// Contents:
//   state_e       controller FSM states
//   DATA_W/STRB_W data word and strobe widths
//   strb_to_mask  4-bit byte strobe -> 32-bit bit mask
package ram_access_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RD_ISSUE   = 3'd1,
        S_RD_CAPTURE = 3'd2,
        S_RESP       = 3'd3,
        S_RMW_ISSUE  = 3'd4,
        S_RMW_MERGE  = 3'd5,
        S_WR_ISSUE   = 3'd6,
        S_WR_GAP     = 3'd7
    } state_e;

    function automatic logic [DATA_W-1:0] strb_to_mask(input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] mask;
        for (int i = 0; i < STRB_W; i++) begin
            mask[8*i +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/ram_strobe_merge.sv
// rtl/ram_strobe_merge.sv - combinational byte-strobe merge of old and new words
//
// Purpose: builds the write word for a partial store: bytes with their
// strobe set come from new_i, the rest are kept from old_i.
// Ports:
//   old_i     [31:0]  word read back from the RAM
//   new_i     [31:0]  store data
//   strb_i    [3:0]   byte enables, bit i covers bits [8i+7:8i]
//   merged_o  [31:0]  merged word
module ram_strobe_merge
    import ram_access_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] old_i,
    input  logic [DATA_W-1:0] new_i,
    input  logic [STRB_W-1:0] strb_i,
    output logic [DATA_W-1:0] merged_o
);

    logic [DATA_W-1:0] mask;

    assign mask     = strb_to_mask(strb_i);
    assign merged_o = (old_i & ~mask) | (new_i & mask);

endmodule

// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - requester-side load/store controller for a single-port block RAM
//
// Purpose: accepts byte-addressed load/store requests, drives the RAM word
// read/write ports, returns load data on a held response channel, and
// inserts a dead cycle after every RAM write so no read ever lands in the
// RAM's write-forwarding window.
// Configuration macro: RAM_ACCESS_CTRL_RMW_EN
//   defined   - partial stores are resolved by read-modify-write, zero-strobe
//               stores are consumed without a RAM access
//   undefined - strobes are ignored, every store writes the full word
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   req_valid_i/req_ready_o           request handshake
//   req_we_i, req_addr_i, req_wstrb_i, req_wdata_i   request fields
//   resp_valid_o/resp_ready_i, resp_rdata_o          load response
//   ram_rden_o, ram_raddr_o, ram_rdata_i             RAM read port
//   ram_wren_o, ram_waddr_o, ram_wdata_o             RAM write port
module ram_access_ctrl
    import ram_access_ctrl_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [WIDTH+1:0]  req_addr_i,
    input  logic [STRB_W-1:0] req_wstrb_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              ram_rden_o,
    output logic [WIDTH-1:0]  ram_raddr_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              ram_wren_o,
    output logic [WIDTH-1:0]  ram_waddr_o,
    output logic [DATA_W-1:0] ram_wdata_o
);

    state_e            state_q, state_d;
    logic              ram_rden_q, ram_rden_d;
    logic [WIDTH-1:0]  ram_raddr_q, ram_raddr_d;
    logic              ram_wren_q, ram_wren_d;
    logic [WIDTH-1:0]  ram_waddr_q, ram_waddr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

    // Byte offset bits never select anything; the word index is the
    // upper WIDTH bits, so addresses wrap naturally at the RAM size.
    logic [WIDTH-1:0]  req_word;
    logic              unused_addr_lsb;

    assign req_word        = req_addr_i[WIDTH+1:2];
    assign unused_addr_lsb = ^req_addr_i[1:0];

`ifdef RAM_ACCESS_CTRL_RMW_EN
    // Store fields held across the read-modify-write sequence.
    logic [WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [DATA_W-1:0] merged;

    ram_strobe_merge u_merge (
        .old_i    (ram_rdata_i),
        .new_i    (wdata_q),
        .strb_i   (wstrb_q),
        .merged_o (merged)
    );
`else
    logic              unused_wstrb;

    assign unused_wstrb = ^req_wstrb_i;
`endif

    // Gated with reset so the controller never advertises readiness
    // while held in reset.
    assign req_ready_o  = (state_q == S_IDLE) && !rst_i;

    assign ram_rden_o   = ram_rden_q;
    assign ram_raddr_o  = ram_raddr_q;
    assign ram_wren_o   = ram_wren_q;
    assign ram_waddr_o  = ram_waddr_q;
    assign ram_wdata_o  = ram_wdata_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            ram_rden_q   <= 1'b0;
            ram_raddr_q  <= '0;
            ram_wren_q   <= 1'b0;
            ram_waddr_q  <= '0;
            ram_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
`ifdef RAM_ACCESS_CTRL_RMW_EN
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ram_rden_q   <= ram_rden_d;
            ram_raddr_q  <= ram_raddr_d;
            ram_wren_q   <= ram_wren_d;
            ram_waddr_q  <= ram_waddr_d;
            ram_wdata_q  <= ram_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
`ifdef RAM_ACCESS_CTRL_RMW_EN
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
`endif
        end
    end

    // RAM strobes are computed one state ahead so the registered outputs
    // line up with the state that owns them.
    always_comb begin
        state_d      = state_q;
        ram_rden_d   = 1'b0;
        ram_raddr_d  = ram_raddr_q;
        ram_wren_d   = 1'b0;
        ram_waddr_d  = ram_waddr_q;
        ram_wdata_d  = ram_wdata_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
`ifdef RAM_ACCESS_CTRL_RMW_EN
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
`ifdef RAM_ACCESS_CTRL_RMW_EN
                    addr_d  = req_word;
                    wdata_d = req_wdata_i;
                    wstrb_d = req_wstrb_i;
`endif
                    if (!req_we_i) begin
                        state_d     = S_RD_ISSUE;
                        ram_rden_d  = 1'b1;
                        ram_raddr_d = req_word;
`ifdef RAM_ACCESS_CTRL_RMW_EN
                    end else if (req_wstrb_i == 4'hF) begin
                        state_d     = S_WR_ISSUE;
                        ram_wren_d  = 1'b1;
                        ram_waddr_d = req_word;
                        ram_wdata_d = req_wdata_i;
                    end else if (req_wstrb_i == 4'h0) begin
                        state_d     = S_IDLE;
                    end else begin
                        state_d     = S_RMW_ISSUE;
                        ram_rden_d  = 1'b1;
                        ram_raddr_d = req_word;
                    end
`else
                    end else begin
                        state_d     = S_WR_ISSUE;
                        ram_wren_d  = 1'b1;
                        ram_waddr_d = req_word;
                        ram_wdata_d = req_wdata_i;
                    end
`endif
                end
            end
            S_RD_ISSUE: begin
                state_d = S_RD_CAPTURE;
            end
            S_RD_CAPTURE: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = ram_rdata_i;
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                end
            end
`ifdef RAM_ACCESS_CTRL_RMW_EN
            S_RMW_ISSUE: begin
                state_d = S_RMW_MERGE;
            end
            S_RMW_MERGE: begin
                state_d     = S_WR_ISSUE;
                ram_wren_d  = 1'b1;
                ram_waddr_d = addr_q;
                ram_wdata_d = merged;
            end
`endif
            S_WR_ISSUE: begin
                state_d = S_WR_GAP;
            end
            S_WR_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb/tb_ram_access_ctrl.sv - directed self-checking bench for ram_access_ctrl
module tb_ram_access_ctrl;

    localparam int WIDTH = 10;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [WIDTH+1:0]  req_addr;
    logic [3:0]        req_wstrb;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              ram_rden;
    logic [WIDTH-1:0]  ram_raddr;
    logic [31:0]       ram_rdata;
    logic              ram_wren;
    logic [WIDTH-1:0]  ram_waddr;
    logic [31:0]       ram_wdata;

    int total = 0;
    int bad   = 0;

    ram_access_ctrl #(.WIDTH(WIDTH)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_wstrb_i  (req_wstrb),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_rdata_o (resp_rdata),
        .ram_rden_o   (ram_rden),
        .ram_raddr_o  (ram_raddr),
        .ram_rdata_i  (ram_rdata),
        .ram_wren_o   (ram_wren),
        .ram_waddr_o  (ram_waddr),
        .ram_wdata_o  (ram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model with the forwarding hazard: a read right after a write
    // returns the last write data regardless of address.
    bit [31:0] mem [1024];
    logic      prev_wren  = 1'b0;
    logic [31:0] prev_wdata = 32'h0;
    int        adj_viol   = 0;
    int        both_viol  = 0;

    always @(posedge clk) begin
        if (ram_rden) ram_rdata <= prev_wren ? prev_wdata : mem[ram_raddr];
        if (ram_wren) mem[ram_waddr] <= ram_wdata;
        if (ram_rden && prev_wren) adj_viol <= adj_viol + 1;
        if (ram_rden && ram_wren) both_viol <= both_viol + 1;
        prev_wren  <= ram_wren;
        prev_wdata <= ram_wdata;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for ready, then performs one request handshake and
    // scrambles the request fields afterwards. Returns just after the
    // handshake edge, i.e. inside cycle A+1.
    task automatic issue(input logic we, input logic [11:0] addr,
                         input logic [3:0] strb, input logic [31:0] data);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", {31'b0, req_ready}, 32'h1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wstrb = strb;
        req_wdata = data;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = ~addr;
        req_wstrb = ~strb;
        req_wdata = ~data;
    endtask

    task automatic take_resp(input string tag, input logic [31:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, {31'b0, resp_valid}, 32'h1);
        check(tag, resp_rdata, exp);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    logic [31:0] exp_part;
    logic [31:0] exp_after_rst;
    int          wren_seen;

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wstrb  = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;

        // Reset state
        #1;
        check("rst_ready", {31'b0, req_ready}, 32'h0);
        repeat (2) @(negedge clk);
        check("rst_outs", {ram_rden, ram_wren, resp_valid, 29'b0}, 32'h0);
        check("rst_wdata", ram_wdata, 32'h0);
        rst = 1'b0;
        #1;
        check("rel_ready", {31'b0, req_ready}, 32'h1);

        // Full store then load, word 4
        issue(1'b1, 12'h010, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        check("fs_wren_a1", {31'b0, ram_wren}, 32'h1);
        check("fs_waddr", {22'b0, ram_waddr}, 32'd4);
        check("fs_wdata", ram_wdata, 32'hDEADBEEF);
        @(negedge clk);
        check("fs_gap", {req_ready, ram_wren, ram_rden, 29'b0}, 32'h0);
        @(negedge clk);
        check("fs_ready_a3", {31'b0, req_ready}, 32'h1);

        issue(1'b0, 12'h010, 4'h0, 32'h0);
        @(negedge clk);
        check("ld_rden_a1", {31'b0, ram_rden}, 32'h1);
        check("ld_raddr", {22'b0, ram_raddr}, 32'd4);
        @(negedge clk);
        check("ld_a2", {ram_rden, resp_valid, 30'b0}, 32'h0);
        @(negedge clk);
        check("ld_valid_a3", {31'b0, resp_valid}, 32'h1);
        check("ld_rdata", resp_rdata, 32'hDEADBEEF);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        check("ld_done", {req_ready, resp_valid, 30'b0}, 32'h80000000);

        // Partial store over preloaded word 4
        issue(1'b1, 12'h010, 4'hF, 32'h11223344);
        issue(1'b1, 12'h012, 4'b0101, 32'hAABBCCDD);
`ifdef RAM_ACCESS_CTRL_RMW_EN
        exp_part = 32'h11BB33DD;
        @(negedge clk);
        check("ps_rden_a1", {ram_rden, ram_wren, 30'b0}, 32'h80000000);
        check("ps_raddr", {22'b0, ram_raddr}, 32'd4);
        @(negedge clk);
        check("ps_merge_a2", {ram_rden, ram_wren, req_ready, 29'b0}, 32'h0);
        @(negedge clk);
        check("ps_wren_a3", {31'b0, ram_wren}, 32'h1);
        check("ps_wdata", ram_wdata, exp_part);
        check("ps_waddr", {22'b0, ram_waddr}, 32'd4);
        @(negedge clk);
        check("ps_gap_a4", {req_ready, ram_wren, 30'b0}, 32'h0);
        @(negedge clk);
        check("ps_ready_a5", {31'b0, req_ready}, 32'h1);
`else
        exp_part = 32'hAABBCCDD;
        @(negedge clk);
        check("ps_wren_a1", {31'b0, ram_wren}, 32'h1);
        check("ps_wdata", ram_wdata, exp_part);
        @(negedge clk);
        @(negedge clk);
        check("ps_ready_a3", {31'b0, req_ready}, 32'h1);
`endif

        // Load with response backpressure
        issue(1'b0, 12'h010, 4'h0, 32'h0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'b0, resp_valid}, 32'h1);
            check("bp_rdata", resp_rdata, exp_part);
            check("bp_ready", {31'b0, req_ready}, 32'h0);
            @(negedge clk);
        end
        take_resp("bp_final", exp_part);
        @(negedge clk);
        check("bp_ready_after", {31'b0, req_ready}, 32'h1);

        // Store to word 2 immediately followed by a load of word 7 (zero)
        issue(1'b1, 12'h008, 4'hF, 32'h12345678);
        issue(1'b0, 12'h01C, 4'h0, 32'h0);
        take_resp("fwd_rdata", 32'h0);

        // Zero-strobe store
        issue(1'b1, 12'h020, 4'h0, 32'hFFFFFFFF);
        @(negedge clk);
`ifdef RAM_ACCESS_CTRL_RMW_EN
        check("zs_no_access", {ram_rden, ram_wren, req_ready, 29'b0}, 32'h20000000);
        issue(1'b0, 12'h020, 4'h0, 32'h0);
        take_resp("zs_word8", 32'h0);
`else
        check("zs_wren", {31'b0, ram_wren}, 32'h1);
        check("zs_waddr", {22'b0, ram_waddr}, 32'd8);
        issue(1'b0, 12'h020, 4'h0, 32'h0);
        take_resp("zs_word8", 32'hFFFFFFFF);
`endif

        // Top of address space
        issue(1'b1, 12'hFFC, 4'hF, 32'hCAFEF00D);
        @(negedge clk);
        check("wrap_waddr", {22'b0, ram_waddr}, 32'd1023);
        issue(1'b0, 12'hFFF, 4'h0, 32'h0);
        @(negedge clk);
        check("wrap_raddr", {22'b0, ram_raddr}, 32'd1023);
        take_resp("wrap_rdata", 32'hCAFEF00D);

        // Reset in the middle of a partial store
        issue(1'b1, 12'h010, 4'b0101, 32'h55667788);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ar_outs", {ram_rden, ram_wren, resp_valid, req_ready, 28'b0}, 32'h0);
        check("ar_rdata", resp_rdata, 32'h0);
        check("ar_wdata", ram_wdata, 32'h0);
        check("ar_addrs", {ram_raddr, ram_waddr, 12'b0}, 32'h0);
        wren_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ram_wren) wren_seen++;
        end
        check("ar_no_wren", wren_seen, 32'd0);
        rst = 1'b0;
        #1;
        check("ar_ready_rel", {31'b0, req_ready}, 32'h1);
`ifdef RAM_ACCESS_CTRL_RMW_EN
        exp_after_rst = 32'h11BB33DD;
`else
        exp_after_rst = 32'h55667788;
`endif
        issue(1'b0, 12'h010, 4'h0, 32'h0);
        take_resp("ar_word4", exp_after_rst);

        repeat (2) @(negedge clk);
        check("no_rd_after_wr", adj_viol, 32'd0);
        check("no_rd_and_wr", both_viol, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Requester-side controller for the single-port block RAM in the memory subsystem. It accepts byte-addressed load/store requests over a valid/ready handshake and drives the RAM's word-wide read and write ports. It returns read data through a held response channel. Partial-word stores are resolved by read-modify-write. The controller also enforces the RAM's write-forwarding hazard: a read issued in the cycle after a write returns the last write data, whatever the read address.

## Interface
- WIDTH, 10, RAM word-address width; request byte address is WIDTH+2 bits
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- REQ_VALID  in  1  request present
- REQ_READY  out  1  controller can accept a request this cycle
- REQ_WE  in  1  1 = store, 0 = load
- REQ_ADDR  in  WIDTH+2  byte address; bits [1:0] ignored, word = REQ_ADDR[WIDTH+1:2]
- REQ_WSTRB  in  4  byte enables for stores, bit i covers WDATA[8i+7:8i]
- REQ_WDATA  in  32  store data
- RESP_VALID  out  1  load data available
- RESP_READY  in  1  consumer takes response
- RESP_RDATA  out  32  load data
- RAM_RDEN  out  1  RAM read enable
- RAM_RADDR  out  WIDTH  RAM read word address
- RAM_RDATA  in  32  RAM read data, valid one cycle after RAM_RDEN
- RAM_WREN  out  1  RAM write enable
- RAM_WADDR  out  WIDTH  RAM write word address
- RAM_WDATA  out  32  RAM write data

## Operation
- States:
  - IDLE
  - RD_ISSUE
  - RD_CAPTURE
  - RESP
  - RMW_ISSUE
  - RMW_MERGE
  - WR_ISSUE
  - WR_GAP
- REQ_READY is 1 only in IDLE. A handshake happens on an edge where REQ_VALID and REQ_READY are both 1.
- Transitions out of IDLE:
  - Load: IDLE → RD_ISSUE.
  - Store with WSTRB = 4'hF: IDLE → WR_ISSUE.
  - Store with WSTRB = 0: request consumed, no RAM access, stays IDLE.
  - Any other store: IDLE → RMW_ISSUE.
- Load path:
  - RD_ISSUE: RAM_RDEN = 1, RAM_RADDR = word address.
  - RD_CAPTURE: RAM_RDATA is captured.
  - RESP: RESP_VALID = 1, RESP_RDATA stable until the RESP_VALID && RESP_READY edge, then → IDLE.
- Store path:
  - RMW_ISSUE: reads the word.
  - RMW_MERGE: merged = (RAM_RDATA & ~mask) | (WDATA & mask), where the mask is the byte-expanded WSTRB.
  - WR_ISSUE: RAM_WREN = 1 with the merged data or the full-word data.
  - WR_GAP: one mandatory idle cycle after every RAM write, then → IDLE. No RAM read ever follows a RAM write in the next cycle.
- All RAM_* outputs and RESP_* outputs are registered. RAM_RDEN and RAM_WREN are never both 1.
- Request fields are latched at handshake. Later changes on REQ_* do not affect the operation in flight.

## Timing
Handshake on edge ending cycle A.
- Load:
  - RAM_RDEN in cycle A+1.
  - RAM_RDATA sampled at end of A+2.
  - RESP_VALID from A+3.
  - REQ_READY returns the cycle after the response handshake.
- Full store: RAM_WREN in A+1, gap in A+2, REQ_READY = 1 in A+3.
- Partial store: RAM_RDEN in A+1, merge in A+2, RAM_WREN in A+3, gap in A+4, REQ_READY = 1 in A+5.
- Zero-strobe store: REQ_READY = 1 in A+1.
- Reset values: REQ_READY = 0 while RST = 1, and 1 in the first cycle after release. Every other output is 0 and the state is IDLE.
- Reset mid-operation aborts immediately. No RAM write is issued after RST asserts, and any pending response is discarded.
- Out-of-range address bits do not exist: the word address is truncated to WIDTH bits, so addresses wrap.

## Configuration
- RAM_ACCESS_CTRL_RMW_EN defined: partial stores use the read-modify-write path described above.
- RAM_ACCESS_CTRL_RMW_EN undefined:
  - REQ_WSTRB is ignored and every store takes the full-word path (WR_ISSUE, WR_GAP).
  - The RMW states and merge logic are not built.

## Structure
- Package ram_access_ctrl_pkg holds:
  - the state encoding constants;
  - the byte-mask expansion function (4-bit strobe to 32-bit mask).
- One sub-module, ram_strobe_merge: a purely combinational merge of old data, new data and strobe. It is instantiated only under RAM_ACCESS_CTRL_RMW_EN.

## Test plan
- Reset, then full store of 32'hDEADBEEF to byte address 0x10, then load from 0x10 → RAM_WREN in A+1 with WADDR = 4, and RESP_RDATA = 32'hDEADBEEF. The load's RAM_RDEN must not be adjacent to RAM_WREN.
- Preload word 4 with 32'h11223344, store 32'hAABBCCDD with WSTRB = 4'b0101 → RAM_WDATA = 32'h11BB33DD, with RAM_WREN in A+3. Without the macro, RAM_WDATA = 32'hAABBCCDD in A+1.
- Load with RESP_READY held 0 for 5 cycles → RESP_VALID and RESP_RDATA are held constant and REQ_READY stays 0 until the response handshake.
- Store to word 2, then immediately request a load of word 7 holding 32'h0 → RESP_RDATA = 32'h0, proving the forwarding hazard is avoided by WR_GAP.
- Assert RST during RMW_MERGE → no RAM_WREN occurs, all outputs are 0, and REQ_READY = 1 in the first cycle after release.
- Zero-strobe store and address 0xFFC with WIDTH = 10 → no RAM access for the zero-strobe store; the 0xFFC access uses word 1023 (wrap boundary).
